// File: rtl/linalg_pkg.sv
// Shared linear-algebra types: the float32 word type and the matrix-vector
// sequencer state encoding.
package linalg_pkg;

  typedef logic [31:0] float32_t;

  typedef enum logic [2:0] {
    LOAD_W   = 3'd0,
    GET_X    = 3'd1,
    PUT_V    = 3'd2,
    GET_PROD = 3'd3,
    PUT_Y    = 3'd4
  } matvec_state_t;

endpackage

// File: rtl/matvec_sequencer.sv
// Matrix-vector sequencer: stores M weight rows, then for each operand vector
// x hands (W[r], x) pairs to an external inner-product unit one row at a time
// and gathers the M scalar results into output_y. Purely a data mover.
// Optional build macro MATVEC_WEIGHT_RELOAD_EN: when defined, the weights are
// reloaded after every result instead of persisting until reset.
module matvec_sequencer
  import linalg_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0][31:0]  input_w_row,
  input  logic                input_w_stb,
  output logic                input_w_ack,
  input  logic [N-1:0][31:0]  input_x,
  input  logic                input_x_stb,
  output logic                input_x_ack,
  output logic [N-1:0][31:0]  ip_v1,
  output logic [N-1:0][31:0]  ip_v2,
  output logic                ip_v1_stb,
  output logic                ip_v2_stb,
  input  logic                ip_v1_ack,
  input  logic                ip_v2_ack,
  input  logic [31:0]         ip_prod,
  input  logic                ip_prod_stb,
  output logic                ip_prod_ack,
  output logic [M-1:0][31:0]  output_y,
  output logic                output_y_stb,
  input  logic                output_y_ack
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(M - 1);

  matvec_state_t     state;
  logic [CW-1:0]     row_cnt;
  logic              v_issued;
  float32_t [M-1:0]  y;
  float32_t [N-1:0]  x_reg;
  float32_t [N-1:0]  w_mem [M];

  logic w_xfer, x_xfer, v1_xfer, v2_xfer, prod_xfer, y_xfer;

  // Each ack/stb is only ever high in its own state, so a transfer is just stb & ack.
  assign w_xfer    = input_w_ack  & input_w_stb;
  assign x_xfer    = input_x_ack  & input_x_stb;
  assign v1_xfer   = ip_v1_stb    & ip_v1_ack;
  assign v2_xfer   = ip_v2_stb    & ip_v2_ack;
  assign prod_xfer = ip_prod_ack  & ip_prod_stb;
  assign y_xfer    = output_y_stb & output_y_ack;

  assign ip_v1    = w_mem[row_cnt];
  assign ip_v2    = x_reg;
  assign output_y = y;

  // Weight and operand storage: plain data capture, meaningless after reset.
  always_ff @(posedge clk) begin
    if (w_xfer) w_mem[row_cnt] <= input_w_row;
    if (x_xfer) x_reg <= input_x;
  end

  // Control FSM: each state raises its stb/ack one cycle after entry, drops it on transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD_W;
      row_cnt      <= '0;
      v_issued     <= 1'b0;
      y            <= '0;
      input_w_ack  <= 1'b0;
      input_x_ack  <= 1'b0;
      ip_v1_stb    <= 1'b0;
      ip_v2_stb    <= 1'b0;
      ip_prod_ack  <= 1'b0;
      output_y_stb <= 1'b0;
    end else begin
      case (state)
        LOAD_W: begin
          if (!input_w_ack) begin
            input_w_ack <= 1'b1;
          end else if (input_w_stb) begin
            if (row_cnt == LAST_ROW) begin
              row_cnt     <= '0;
              input_w_ack <= 1'b0;
              state       <= GET_X;
            end else begin
              row_cnt <= row_cnt + CW'(1);
            end
          end
        end

        GET_X: begin
          if (!input_x_ack) begin
            input_x_ack <= 1'b1;
          end else if (input_x_stb) begin
            input_x_ack <= 1'b0;
            state       <= PUT_V;
          end
        end

        PUT_V: begin
          // v_issued separates "not yet raised" from "raised and already taken".
          if (!v_issued) begin
            ip_v1_stb <= 1'b1;
            ip_v2_stb <= 1'b1;
            v_issued  <= 1'b1;
          end else begin
            if (v1_xfer) ip_v1_stb <= 1'b0;
            if (v2_xfer) ip_v2_stb <= 1'b0;
            if ((!ip_v1_stb || v1_xfer) && (!ip_v2_stb || v2_xfer)) begin
              v_issued <= 1'b0;
              state    <= GET_PROD;
            end
          end
        end

        GET_PROD: begin
          if (!ip_prod_ack) begin
            ip_prod_ack <= 1'b1;
          end else if (ip_prod_stb) begin
            y[row_cnt]  <= ip_prod;
            ip_prod_ack <= 1'b0;
            if (row_cnt != LAST_ROW) begin
              row_cnt <= row_cnt + CW'(1);
              state   <= PUT_V;
            end else begin
              row_cnt <= '0;
              state   <= PUT_Y;
            end
          end
        end

        PUT_Y: begin
          if (!output_y_stb) begin
            output_y_stb <= 1'b1;
          end else if (output_y_ack) begin
            output_y_stb <= 1'b0;
`ifdef MATVEC_WEIGHT_RELOAD_EN
            state <= LOAD_W;
`else
            state <= GET_X;
`endif
          end
        end

        default: state <= LOAD_W;
      endcase
    end
  end

endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed bench for matvec_sequencer with N=2, M=2. The bench plays the
// weight/operand sources, the inner-product unit (returning hand-computed
// float32 dot products) and the result sink.
module tb_matvec_sequencer;

  localparam int N = 2;
  localparam int M = 2;

  logic               clk;
  logic               rst;
  logic [N-1:0][31:0] input_w_row;
  logic               input_w_stb;
  logic               input_w_ack;
  logic [N-1:0][31:0] input_x;
  logic               input_x_stb;
  logic               input_x_ack;
  logic [N-1:0][31:0] ip_v1;
  logic [N-1:0][31:0] ip_v2;
  logic               ip_v1_stb;
  logic               ip_v2_stb;
  logic               ip_v1_ack;
  logic               ip_v2_ack;
  logic [31:0]        ip_prod;
  logic               ip_prod_stb;
  logic               ip_prod_ack;
  logic [M-1:0][31:0] output_y;
  logic               output_y_stb;
  logic               output_y_ack;

  logic [5:0] ctrl;
  assign ctrl = {input_w_ack, input_x_ack, ip_v1_stb, ip_v2_stb, ip_prod_ack, output_y_stb};

  int checks = 0;
  int errors = 0;

  matvec_sequencer #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst),
    .input_w_row(input_w_row), .input_w_stb(input_w_stb), .input_w_ack(input_w_ack),
    .input_x(input_x), .input_x_stb(input_x_stb), .input_x_ack(input_x_ack),
    .ip_v1(ip_v1), .ip_v2(ip_v2), .ip_v1_stb(ip_v1_stb), .ip_v2_stb(ip_v2_stb),
    .ip_v1_ack(ip_v1_ack), .ip_v2_ack(ip_v2_ack),
    .ip_prod(ip_prod), .ip_prod_stb(ip_prod_stb), .ip_prod_ack(ip_prod_ack),
    .output_y(output_y), .output_y_stb(output_y_stb), .output_y_ack(output_y_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  localparam logic [31:0] F0_0 = 32'h00000000;
  localparam logic [31:0] F0_5 = 32'h3F000000;
  localparam logic [31:0] F1_0 = 32'h3F800000;
  localparam logic [31:0] F2_0 = 32'h40000000;
  localparam logic [31:0] F3_0 = 32'h40400000;
  localparam logic [31:0] F4_0 = 32'h40800000;
  localparam logic [31:0] F5_0 = 32'h40A00000;
  localparam logic [31:0] F7_0 = 32'h40E00000;
  localparam logic [31:0] F8_0 = 32'h41000000;
  localparam logic [31:0] F11_0 = 32'h41300000;

  typedef struct {
    logic [N-1:0][31:0] x;
    logic [31:0]        p0;
    logic [31:0]        p1;
    logic [M-1:0][31:0] y;
  } vec_t;

  vec_t tv [3];
  logic [N-1:0][31:0] w0, w1;

  function automatic logic [63:0] pack2(input logic [31:0] e0, input logic [31:0] e1);
    return {e1, e0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_w(input logic [N-1:0][31:0] row);
    int n = 0;
    @(negedge clk);
    input_w_row = row;
    input_w_stb = 1'b1;
    while (!input_w_ack && n < 20) begin @(negedge clk); n++; end
    check("w_ack_wait", 64'(input_w_ack), 64'd1);
    @(posedge clk); #1;
    input_w_stb = 1'b0;
  endtask

  task automatic send_x(input logic [N-1:0][31:0] xv);
    int n = 0;
    @(negedge clk);
    input_x = xv;
    input_x_stb = 1'b1;
    while (!input_x_ack && n < 20) begin @(negedge clk); n++; end
    check("x_ack_wait", 64'(input_x_ack), 64'd1);
    @(posedge clk); #1;
    input_x_stb = 1'b0;
  endtask

  task automatic wait_v_stbs();
    int n = 0;
    @(negedge clk);
    while (!(ip_v1_stb && ip_v2_stb) && n < 20) begin @(negedge clk); n++; end
    check("v_stbs_wait", 64'({ip_v1_stb, ip_v2_stb}), 64'd3);
  endtask

  task automatic get_prod(input logic [31:0] prod);
    int n = 0;
    ip_prod = prod;
    ip_prod_stb = 1'b1;
    @(negedge clk);
    while (!ip_prod_ack && n < 20) begin @(negedge clk); n++; end
    check("prod_ack_wait", 64'(ip_prod_ack), 64'd1);
    @(posedge clk); #1;
    ip_prod_stb = 1'b0;
  endtask

  task automatic do_ip(input logic [N-1:0][31:0] ev1, input logic [N-1:0][31:0] ev2,
                       input logic [31:0] prod);
    wait_v_stbs();
    check("ip_v1_row", 64'(ip_v1), 64'(ev1));
    check("ip_v2_x", 64'(ip_v2), 64'(ev2));
    check("w_ack_idle", 64'(input_w_ack), 64'd0);
    ip_v1_ack = 1'b1;
    ip_v2_ack = 1'b1;
    @(posedge clk); #1;
    ip_v1_ack = 1'b0;
    ip_v2_ack = 1'b0;
    get_prod(prod);
  endtask

  task automatic get_y(input logic [M-1:0][31:0] exp);
    int n = 0;
    @(negedge clk);
    while (!output_y_stb && n < 20) begin @(negedge clk); n++; end
    check("y_stb_wait", 64'(output_y_stb), 64'd1);
    check("output_y", 64'(output_y), 64'(exp));
    output_y_ack = 1'b1;
    @(posedge clk); #1;
    output_y_ack = 1'b0;
  endtask

  // Called right after a result transfer: one cycle later the next state's ack is up.
  task automatic after_y_check();
    @(posedge clk); #1;
`ifdef MATVEC_WEIGHT_RELOAD_EN
    check("next_state_acks", 64'({input_x_ack, input_w_ack}), 64'd1);
`else
    check("next_state_acks", 64'({input_x_ack, input_w_ack}), 64'd2);
`endif
  endtask

  task automatic reload_if_enabled();
`ifdef MATVEC_WEIGHT_RELOAD_EN
    send_w(w0);
    send_w(w1);
`endif
  endtask

  initial begin
    logic [N-1:0][31:0] xc;

    w0 = pack2(F1_0, F2_0);
    w1 = pack2(F3_0, F4_0);
    tv[0] = '{x: pack2(F1_0, F1_0), p0: F3_0, p1: F7_0, y: pack2(F3_0, F7_0)};
    tv[1] = '{x: pack2(F2_0, F0_5), p0: F3_0, p1: F8_0, y: pack2(F3_0, F8_0)};
    tv[2] = '{x: pack2(F0_0, F1_0), p0: F2_0, p1: F4_0, y: pack2(F2_0, F4_0)};

    rst = 1'b1;
    input_w_row = '0; input_w_stb = 1'b0;
    input_x = '0; input_x_stb = 1'b0;
    ip_v1_ack = 1'b0; ip_v2_ack = 1'b0;
    ip_prod = '0; ip_prod_stb = 1'b0;
    output_y_ack = 1'b0;

    #3;
    check("reset_ctrl", 64'(ctrl), 64'd0);
    check("reset_y", 64'(output_y), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_release_ctrl", 64'(ctrl), 64'd0);
    @(posedge clk); #1;
    check("first_w_ack", 64'(ctrl), 64'b100000);

    send_w(w0);
    send_w(w1);
    check("w_ack_dropped", 64'(input_w_ack), 64'd0);

    for (int i = 0; i < 3; i++) begin
      if (i > 0) reload_if_enabled();
      send_x(tv[i].x);
      do_ip(w0, tv[i].x, tv[i].p0);
      do_ip(w1, tv[i].x, tv[i].p1);
      get_y(tv[i].y);
      after_y_check();
    end

    // Staggered v1/v2 acks, with a spurious product strobe while in PUT_V.
    reload_if_enabled();
    xc = pack2(F1_0, F2_0);
    send_x(xc);
    wait_v_stbs();
    check("stagger_v1", 64'(ip_v1), 64'(w0));
    ip_prod = 32'hDEADBEEF;
    ip_prod_stb = 1'b1;
    ip_v1_ack = 1'b1;
    @(posedge clk); #1;
    ip_v1_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stagger_hold", 64'({ip_v1_stb, ip_v2_stb, ip_prod_ack}), 64'b010);
      if (k == 2) begin
        ip_v2_ack = 1'b1;
        ip_prod_stb = 1'b0;
      end
    end
    @(posedge clk); #1;
    ip_v2_ack = 1'b0;
    check("spurious_y_unchanged", 64'(output_y), 64'(tv[2].y));
    check("v_stbs_low", 64'({ip_v1_stb, ip_v2_stb}), 64'd0);
    get_prod(F5_0);
    do_ip(w1, xc, F11_0);

    // Result sink stalls for 10 cycles.
    begin
      int n = 0;
      @(negedge clk);
      while (!output_y_stb && n < 20) begin @(negedge clk); n++; end
      for (int k = 0; k < 10; k++) begin
        check("y_stall", {output_y_stb, input_x_ack, 62'(output_y)},
              {1'b1, 1'b0, 62'(pack2(F5_0, F11_0))});
        @(negedge clk);
      end
      check("y_stall_end", 64'(output_y), 64'(pack2(F5_0, F11_0)));
      output_y_ack = 1'b1;
      @(posedge clk); #1;
      output_y_ack = 1'b0;
    end
    after_y_check();

    // Reset asserted while row 1 is being offered.
    reload_if_enabled();
    xc = pack2(F1_0, F1_0);
    send_x(xc);
    do_ip(w0, xc, F3_0);
    wait_v_stbs();
    check("row1_before_reset", 64'(ip_v1), 64'(w1));
    #2;
    rst = 1'b1;
    #1;
    check("midrun_reset_ctrl", 64'(ctrl), 64'd0);
    check("midrun_reset_y", 64'(output_y), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrun_release_ctrl", 64'(ctrl), 64'd0);
    @(posedge clk); #1;
    check("midrun_load_w", 64'(ctrl), 64'b100000);

    w0 = pack2(F2_0, F0_0);
    w1 = pack2(F0_0, F2_0);
    send_w(w0);
    send_w(w1);
    send_x(xc);
    do_ip(w0, xc, F2_0);
    do_ip(w1, xc, F2_0);
    get_y(pack2(F2_0, F2_0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matvec_sequencer.md
MATVEC_SEQUENCER -- requirements
Module: matvec_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, meaning vector length, i.e. elements per row (float32).
REQ-002 SHALL have parameter M, default 4, meaning the number of matrix rows (output length).
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have input_w_row, input, [N-1:0][31:0]: one weight row; input_w_stb, input, 1; input_w_ack, output, 1.
REQ-006 SHALL have input_x, input, [N-1:0][31:0]: the operand vector; input_x_stb, input, 1; input_x_ack, output, 1.
REQ-007 SHALL have ip_v1, output, [N-1:0][31:0] (row); ip_v2, output, [N-1:0][31:0] (x); ip_v1_stb and ip_v2_stb, output, 1 each; ip_v1_ack and ip_v2_ack, input, 1 each.
REQ-008 SHALL have ip_prod, input, [31:0]; ip_prod_stb, input, 1; ip_prod_ack, output, 1: the result return path from the downstream inner-product unit.
REQ-009 SHALL have output_y, output, [M-1:0][31:0]; output_y_stb, output, 1; output_y_ack, input, 1.

Function
REQ-010 SHALL complete a transfer on any clock edge where both stb and ack are sampled high; the driving side SHALL hold data stable while its stb is high.
REQ-011 SHALL use the states LOAD_W, GET_X, PUT_V, GET_PROD and PUT_Y.
REQ-012 LOAD_W SHALL assert input_w_ack and store each accepted row at index row_cnt; after row M-1 it SHALL go to GET_X with row_cnt cleared.
REQ-013 GET_X SHALL assert input_x_ack, latch input_x on transfer, deassert the ack and go to PUT_V.
REQ-014 PUT_V SHALL drive ip_v1 = W[row_cnt] and ip_v2 = x, and assert both stbs.
REQ-015 In PUT_V, each stb SHALL drop independently on its own transfer; the state SHALL move to GET_PROD only once both have transferred, in any order or in the same cycle.
REQ-016 GET_PROD SHALL assert ip_prod_ack and write ip_prod into y[row_cnt] on transfer.
REQ-017 After the GET_PROD transfer: if row_cnt < M-1, row_cnt SHALL increment and the state SHALL go to PUT_V; otherwise row_cnt SHALL clear and the state SHALL go to PUT_Y.
REQ-018 PUT_Y SHALL assert output_y_stb with output_y = y; on transfer it SHALL drop the stb and go to GET_X (or to LOAD_W per REQ-024).
REQ-019 SHALL have at most one inner product in flight; ip_prod_stb arriving outside GET_PROD SHALL be ignored (not acked).
REQ-020 Latency from each handshake state entry to its stb/ack assertion SHALL be one cycle; the module SHALL add no other wait cycles.
REQ-021 Row index 0 SHALL map to output_y[0]; the module SHALL perform no arithmetic on the data.

Reset
REQ-022 On rst assertion, all stb/ack outputs, output_y, y and row_cnt SHALL be 0 and the state SHALL be LOAD_W, immediately and regardless of the clock, including mid-transfer.
REQ-023 After reset, no output SHALL assert before the first clk edge with rst low; stored weights are invalid after reset.

Configuration
REQ-024 With MATVEC_WEIGHT_RELOAD_EN defined, PUT_Y SHALL return to LOAD_W, reloading all M rows per operand vector.
REQ-025 Without MATVEC_WEIGHT_RELOAD_EN, PUT_Y SHALL return to GET_X and weights SHALL persist until reset.

Structure
REQ-026 The shared package linalg_pkg SHALL hold the float32_t typedef ([31:0]) and the matvec state enum.
REQ-027 The module SHALL have no sub-module; the parent SHALL instantiate inner_product #(.N(N)) and wire it to the ip_* ports.

Verification
REQ-028 N=2, M=2, W={{1.0,2.0},{3.0,4.0}}, x={1.0,1.0}, with the real inner_product downstream -> output_y[0]=0x40400000 (3.0) and output_y[1]=0x40E00000 (7.0).
REQ-029 ip_v2_ack 3 cycles after ip_v1_ack -> ip_v1_stb low after its transfer, ip_v2_stb held high, no GET_PROD entry until the v2 transfer.
REQ-030 output_y_ack held low for 10 cycles -> output_y_stb and data stable throughout, no input_x_ack asserted.
REQ-031 rst pulsed during PUT_V of row 1 -> all stbs and acks 0 within the same cycle; state LOAD_W (input_w_ack asserted) one cycle after release.
REQ-032 Two consecutive x vectors without MATVEC_WEIGHT_RELOAD_EN -> second result computed with no input_w_ack; with the macro defined -> M row loads required between results.
REQ-033 Spurious ip_prod_stb asserted during PUT_V -> ip_prod_ack stays 0 and y is unchanged.
